// File: rtl/store_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : store_byte_serializer
// Description : Narrows a 32-bit store value to byte/halfword/word according to
//               the MIPS store opcode (SB/SH/SW) and writes it big-endian, one
//               byte per memory handshake, onto a byte-wide memory port.
//               Optional feature macro: ACK_TIMEOUT_EN (per-byte mem_ack
//               timeout of TIMEOUT_CYC cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module store_byte_serializer #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2b;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // A zero or negative timeout would make the wait counter meaningless
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("store_byte_serializer: TIMEOUT_CYC must be >= 1");
  end

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  // Narrowed value left-aligned so byte[i] always sits at bits [31-8i -: 8]
  logic [31:0]         data_q, data_d;
  logic [1:0]          last_q, last_d;   // index of the final byte (count-1)
  logic [1:0]          idx_q, idx_d;

  // Opcode/alignment decode of the incoming request
  logic                op_ok;
  logic [31:0]         op_data;
  logic [1:0]          op_last;
  logic [1:0]          idx_next;

  // Decide whether the request is legal and build its left-aligned payload
  always_comb begin
    op_ok   = 1'b0;
    op_data = 32'h0;
    op_last = 2'd0;
    case (opcode)
      OP_SB: begin
        op_ok   = 1'b1;
        op_data = {wdata[7:0], 24'h0};
        op_last = 2'd0;
      end
      OP_SH: begin
        op_ok   = ~addr[0];
        op_data = {wdata[15:0], 16'h0};
        op_last = 2'd1;
      end
      OP_SW: begin
        op_ok   = (addr[1:0] == 2'b00);
        op_data = wdata;
        op_last = 2'd3;
      end
      default: begin
        op_ok   = 1'b0;
      end
    endcase
  end

  assign idx_next = idx_q + 2'd1;

`ifdef ACK_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  // Next-state and registered-output logic of the serializer FSM
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    base_d      = base_q;
    data_d      = data_q;
    last_d      = last_q;
    idx_d       = idx_q;
`ifdef ACK_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        mem_we_d    = 1'b0;
        if (req_valid) begin
          if (op_ok) begin
            state_d     = ST_WRITE;
            req_ready_d = 1'b0;
            base_d      = addr;
            data_d      = op_data;
            last_d      = op_last;
            idx_d       = 2'd0;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr;
            mem_wdata_d = op_data[31:24];
`ifdef ACK_TIMEOUT_EN
            wait_d      = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (idx_q == last_q) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            mem_we_d    = 1'b0;
            done_d      = 1'b1;
            idx_d       = 2'd0;
          end else begin
            idx_d       = idx_next;
            mem_addr_d  = base_q + ADDR_W'(idx_next);
            mem_wdata_d = data_q[8*(3-idx_next) +: 8];
          end
`ifdef ACK_TIMEOUT_EN
          wait_d = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) begin
          // Memory never answered: drop the remaining bytes
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          mem_we_d    = 1'b0;
          err_d       = 1'b1;
          idx_d       = 2'd0;
          wait_d      = '0;
        end else begin
          wait_d = wait_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        mem_we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any store in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      base_q      <= '0;
      data_q      <= 32'h0;
      last_q      <= 2'd0;
      idx_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      base_q      <= base_d;
      data_q      <= data_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
    end
  end

`ifdef ACK_TIMEOUT_EN
  // Per-byte wait counter for the ack timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign req_ready = req_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire
